// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer between pipeline stages: main register drives the outputs,
// skid register absorbs one entry when the downstream stalls. in_ready_o is registered.
module pipe_skid_reg #(
    parameter int DATA_W = 69,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e              state_r;
    logic [DATA_W-1:0]   main_data_r;
    logic [CTRL_W-1:0]   main_ctrl_r;
    logic [DATA_W-1:0]   skid_data_r;
    logic [CTRL_W-1:0]   skid_ctrl_r;
    logic                out_valid_r;
    logic                in_ready_r;
    logic                in_xfer_s;
    logic                out_xfer_s;

    assign in_xfer_s   = in_valid_i & in_ready_r;
    assign out_xfer_s  = out_valid_r & out_ready_i;

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign ctrl_o      = main_ctrl_r;
    assign data_o      = main_data_r;

    // Buffer state machine; main_ctrl_r is forced to zero whenever the output is a bubble
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= EMPTY;
            main_data_r <= {DATA_W{1'b0}};
            main_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
            skid_ctrl_r <= {CTRL_W{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else if (flush_i) begin
            // Flush wins over any coincident transfer; data_o keeps its last value
            state_r     <= EMPTY;
            main_ctrl_r <= {CTRL_W{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_xfer_s) begin
                        main_data_r <= data_i;
                        main_ctrl_r <= ctrl_i;
                        out_valid_r <= 1'b1;
                        state_r     <= ONE;
                    end else begin
                        state_r     <= EMPTY;
                    end
                end
                ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        main_data_r <= data_i;
                        main_ctrl_r <= ctrl_i;
                    end else if (in_xfer_s) begin
                        skid_data_r <= data_i;
                        skid_ctrl_r <= ctrl_i;
                        in_ready_r  <= 1'b0;
                        state_r     <= FULL;
                    end else if (out_xfer_s) begin
                        main_ctrl_r <= {CTRL_W{1'b0}};
                        out_valid_r <= 1'b0;
                        state_r     <= EMPTY;
                    end else begin
                        state_r     <= ONE;
                    end
                end
                FULL: begin
                    if (out_xfer_s) begin
                        main_data_r <= skid_data_r;
                        main_ctrl_r <= skid_ctrl_r;
                        in_ready_r  <= 1'b1;
                        state_r     <= ONE;
                    end else begin
                        state_r     <= FULL;
                    end
                end
                default: begin
                    main_ctrl_r <= {CTRL_W{1'b0}};
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 69, meaning width of the datapath payload (ALU result, store data and destination register).
REQ-002 The block SHALL have parameter CTRL_W, default 4, meaning width of the control bundle (RegWrite, MemtoReg, MemRead, MemWrite).
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1, reset; asynchronous, active-low.
REQ-005 The block SHALL have port flush_i, input, 1, synchronous flush: discard all held entries.
REQ-006 The block SHALL have port in_valid_i, input, 1, upstream entry present.
REQ-007 The block SHALL have port in_ready_o, output, 1, block can accept an entry this cycle.
REQ-008 The block SHALL have port ctrl_i, input, CTRL_W, upstream control bundle.
REQ-009 The block SHALL have port data_i, input, DATA_W, upstream payload.
REQ-010 The block SHALL have port out_valid_o, output, 1, downstream entry present.
REQ-011 The block SHALL have port out_ready_i, input, 1, downstream accepts the entry this cycle.
REQ-012 The block SHALL have port ctrl_o, output, CTRL_W, downstream control bundle.
REQ-013 The block SHALL have port data_o, output, DATA_W, downstream payload.

Function
REQ-014 The block SHALL implement a two-entry skid buffer (main register driving outputs, skid register behind it) with states EMPTY, ONE, FULL.
REQ-015 An input transfer SHALL occur when in_valid_i and in_ready_o are both 1; an output transfer SHALL occur when out_valid_o and out_ready_i are both 1.
REQ-016 in_ready_o SHALL be a registered signal, equal to 1 in EMPTY and ONE and 0 in FULL, with no combinational path from out_ready_i.
REQ-017 out_valid_o SHALL be 1 in ONE and FULL and 0 in EMPTY; ctrl_o and data_o SHALL always come from the main register.
REQ-018 EMPTY: on an input transfer, the main register SHALL load the input and the state SHALL go to ONE; otherwise the state SHALL remain EMPTY.
REQ-019 ONE with an input transfer and an output transfer: the main register SHALL load the input and the state SHALL stay ONE.
REQ-020 ONE with an input transfer only: the skid register SHALL load the input and the state SHALL go to FULL.
REQ-021 ONE with an output transfer only: the state SHALL go to EMPTY.
REQ-022 FULL with an output transfer: the main register SHALL load the skid contents and the state SHALL go to ONE; otherwise the state SHALL hold.
REQ-023 Minimum latency SHALL be 1 cycle (input accepted at edge N appears on outputs after edge N); sustained throughput SHALL be one entry per cycle when out_ready_i is held at 1.
REQ-024 Entries SHALL leave in acceptance order; no entry SHALL be dropped or duplicated except by flush or reset.
REQ-025 ctrl_o SHALL be all-zero whenever out_valid_o is 0 (a bubble never asserts RegWrite or MemWrite).
REQ-026 data_o SHALL hold its last value while out_valid_o is 0.
REQ-027 flush_i SHALL take priority over all transfers in the same cycle: the next state SHALL be EMPTY, ctrl_o SHALL be 0, in_ready_o SHALL be 1, and any coincident input SHALL be discarded.
REQ-028 Held outputs SHALL remain stable while out_valid_o=1 and out_ready_i=0.

Reset
REQ-029 When rst_i is low, the block SHALL immediately and asynchronously clear to EMPTY with out_valid_o=0, in_ready_o=1, ctrl_o=0, data_o=0, and skid contents=0, regardless of the clock.
REQ-030 Reset asserted mid-operation, including in FULL, SHALL discard both entries; the first input transfer after rst_i rises SHALL behave as from EMPTY.

Verification
REQ-031 Stream: out_ready_i=1, apply data_i=1..8 with ctrl_i=4'b1001 on consecutive cycles -> data_o=1..8 on consecutive cycles, each one cycle later, with in_ready_o constantly 1.
REQ-032 Backpressure: accept A=0x11, then hold out_ready_i=0 and offer B=0x22 -> FULL and in_ready_o=0 after the next edge; release -> A then B each appear exactly once, in order.
REQ-033 Flush: in FULL with C=0x33 offered and flush_i=1 -> next cycle out_valid_o=0, ctrl_o=0, in_ready_o=1; C never appears.
REQ-034 Async reset: in FULL, pull rst_i low between clock edges -> outputs clear to 0 before the next edge; after release, entry 0x44 emerges after 1 cycle.
REQ-035 Random stress: 10k cycles of random in_valid_i, out_ready_i and flush_i -> output sequence matches a reference FIFO model, and no stall lasts longer than out_ready_i is held low.
